// File: rtl/divider_8_by_4_bit_unsigned_v.sv
// Sequential restoring divider: 8-bit dividend / 4-bit divisor, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero saturates the results and raises o_dz.
module divider_8_by_4_bit_unsigned_v (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_fu,
  input  logic [3:0] i_bu,
  output logic [7:0] o_qu,
  output logic [3:0] o_ru,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_dz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_fu;
  logic [3:0] r_bu;
  logic [4:0] r_rem;
  logic [7:0] r_q;
  logic [2:0] r_cnt;
  logic [7:0] r_qu;
  logic [3:0] r_ru;
  logic       r_busy;
  logic       r_done;
  logic       r_dz;

  logic [4:0] w_shift;
  logic       w_ge;
  logic [4:0] w_rem_nxt;
  logic [7:0] w_q_nxt;

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  always_comb begin
    w_shift   = {r_rem[3:0], r_fu[7]};
    w_ge      = (w_shift >= {1'b0, r_bu});
    w_rem_nxt = w_shift;
    if (w_ge) begin
      w_rem_nxt = w_shift - {1'b0, r_bu};
    end else begin
      w_rem_nxt = w_shift;
    end
    w_q_nxt = {r_q[6:0], w_ge};
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (i_bu == 4'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_CALC;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_CALC;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand capture, iteration datapath and registered results.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fu   <= 8'd0;
      r_bu   <= 4'd0;
      r_rem  <= 5'd0;
      r_q    <= 8'd0;
      r_cnt  <= 3'd0;
      r_qu   <= 8'd0;
      r_ru   <= 4'd0;
      r_dz   <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_fu  <= i_fu;
            r_bu  <= i_bu;
            r_rem <= 5'd0;
            r_q   <= 8'd0;
            r_cnt <= 3'd7;
            if (i_bu == 4'd0) begin
              r_qu <= 8'hFF;
              r_ru <= 4'hF;
              r_dz <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_fu  <= {r_fu[6:0], 1'b0};
          r_rem <= w_rem_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - 3'd1;
          // Final iteration publishes the results the same edge it computes them.
          if (r_cnt == 3'd0) begin
            r_qu <= w_q_nxt;
            r_ru <= w_rem_nxt[3:0];
            r_dz <= 1'b0;
          end
        end
        S_DONE: begin
          r_cnt <= 3'd0;
        end
        default: begin
          r_cnt <= 3'd0;
        end
      endcase
    end
  end

  assign o_qu   = r_qu;
  assign o_ru   = r_ru;
  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_dz   = r_dz;

endmodule

// File: tb/tb_divider_8_by_4_bit_unsigned_v.sv
// Randomised and directed bench for the 8/4 divider, checked every cycle against
// an arithmetic model of the handshake and results.
module tb_divider_8_by_4_bit_unsigned_v;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_fu = 8'd0;
  logic [3:0] i_bu = 4'd0;
  logic [7:0] o_qu;
  logic [3:0] o_ru;
  logic       o_busy, o_done, o_dz;

  int n_vec  = 0;
  int n_fail = 0;

  divider_8_by_4_bit_unsigned_v dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_fu(i_fu), .i_bu(i_bu),
    .o_qu(o_qu), .o_ru(o_ru), .o_busy(o_busy), .o_done(o_done), .o_dz(o_dz)
  );

  always #5 clk = ~clk;

  // Model: results from / and %, timing as "done 8 edges after accept, idle one edge later".
  logic [7:0] m_qu = 8'd0, m_pq = 8'd0;
  logic [3:0] m_ru = 4'd0, m_pr = 4'd0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  int         m_left = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_qu <= 8'd0; m_ru <= 4'd0; m_dz <= 1'b0;
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= 0;
    end else if (!m_busy) begin
      m_done <= 1'b0;
      if (i_start) begin
        m_busy <= 1'b1;
        if (i_bu == 4'd0) begin
          m_qu <= 8'hFF; m_ru <= 4'hF; m_dz <= 1'b1; m_done <= 1'b1; m_left <= 0;
        end else begin
          m_pq <= 8'(i_fu / i_bu);
          m_pr <= 4'(i_fu % i_bu);
          m_left <= 8;
        end
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_qu <= m_pq; m_ru <= m_pr; m_dz <= 1'b0; m_done <= 1'b1;
      end
    end else begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("busy", 32'(o_busy), 32'(m_busy));
    chk("done", 32'(o_done), 32'(m_done));
    chk("qu",   32'(o_qu),   32'(m_qu));
    chk("ru",   32'(o_ru),   32'(m_ru));
    chk("dz",   32'(o_dz),   32'(m_dz));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  // Accept a division, count edges to o_done, then let the block return to idle.
  task automatic do_div(input logic [7:0] fu, input logic [3:0] bu, output int lat);
    i_fu = fu; i_bu = bu; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    lat = 0;
    while (!o_done && lat < 20) begin
      tick();
      lat++;
    end
    if (lat >= 20) begin
      n_vec++; n_fail++;
      $display("FAIL timeout: no o_done after %0d cycles, expected 8", lat);
    end
  endtask

  task automatic run_chk(input string name, input logic [7:0] fu, input logic [3:0] bu,
                         input int eq, input int er, input int elat);
    int lat;
    do_div(fu, bu, lat);
    chk({name, "_lat"}, 32'(lat), 32'(elat));
    chk({name, "_q"},   32'(o_qu), 32'(eq));
    chk({name, "_r"},   32'(o_ru), 32'(er));
    tick();
    chk({name, "_idle"}, 32'(o_busy), 32'd0);
  endtask

  initial begin
    int lat;
    logic [7:0] fu;
    logic [3:0] bu;
    #1 rst = 1'b1;
    #11;
    chk("rst_qu", 32'(o_qu), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("idle_busy", 32'(o_busy), 32'd0);

    // Nominal case, with busy width measured directly.
    begin
      int busy_cnt;
      i_fu = 8'd200; i_bu = 4'd7; i_start = 1'b1;
      tick();
      i_start = 1'b0;
      busy_cnt = 1;
      for (int i = 0; i < 8; i++) begin
        if (i < 7) chk("200_7_early_done", 32'(o_done), 32'd0);
        tick();
        if (o_busy) busy_cnt++;
      end
      chk("200_7_done", 32'(o_done), 32'd1);
      chk("200_7_q", 32'(o_qu), 32'd28);
      chk("200_7_r", 32'(o_ru), 32'd4);
      chk("200_7_dz", 32'(o_dz), 32'd0);
      tick();
      chk("200_7_busy_len", 32'(busy_cnt), 32'd9);
      chk("200_7_idle", 32'(o_busy), 32'd0);
    end

    run_chk("255_1", 8'd255, 4'd1, 255, 0, 8);
    run_chk("15_15", 8'd15, 4'd15, 1, 0, 8);
    run_chk("5_13", 8'd5, 4'd13, 0, 5, 8);
    run_chk("0_9", 8'd0, 4'd9, 0, 0, 8);
    run_chk("100_0", 8'd100, 4'd0, 255, 15, 0);
    chk("100_0_dz_clear", 32'(o_done), 32'd0);
    run_chk("100_10", 8'd100, 4'd10, 10, 0, 8);
    chk("100_10_dz", 32'(o_dz), 32'd0);

    // Requests while busy are ignored; a held start is taken at the first idle edge.
    i_fu = 8'd200; i_bu = 4'd7; i_start = 1'b1;
    tick();
    i_fu = 8'd50; i_bu = 4'd3;
    for (int i = 0; i < 8; i++) tick();
    chk("ign_done", 32'(o_done), 32'd1);
    chk("ign_q", 32'(o_qu), 32'd28);
    chk("ign_r", 32'(o_ru), 32'd4);
    tick();
    chk("ign_idle", 32'(o_busy), 32'd0);
    tick();
    chk("n10_busy", 32'(o_busy), 32'd1);
    i_start = 1'b0;
    lat = 0;
    while (!o_done && lat < 20) begin tick(); lat++; end
    chk("n10_lat", 32'(lat), 32'd8);
    chk("n10_q", 32'(o_qu), 32'd16);
    chk("n10_r", 32'(o_ru), 32'd2);
    tick();

    // Reset mid-calculation.
    i_fu = 8'd200; i_bu = 4'd7; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_done", 32'(o_done), 32'd0);
    chk("mid_rst_qu", 32'(o_qu), 32'd0);
    chk("mid_rst_ru", 32'(o_ru), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_nodone", 32'(o_done), 32'd0);
    end
    run_chk("77_6", 8'd77, 4'd6, 12, 5, 8);

    // Random operands, roughly one in eight a zero divisor.
    for (int i = 0; i < 60; i++) begin
      fu = 8'($urandom_range(0, 255));
      bu = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      do_div(fu, bu, lat);
      chk("rnd_lat", 32'(lat), (bu == 4'd0) ? 32'd0 : 32'd8);
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
